// File: rtl/vend_slot_arbiter.sv
// Two-slot arbiter in front of a single vending_machine core: round-robin session grant,
// coin forwarding, vend completion/change return. Define VEND_TIMEOUT_EN for the idle-session abort.

module vend_slot_lane (
    input  logic       req,
    input  logic       own,
    input  logic [1:0] coin,
    output logic       take
);
    // Only 5 (01) and 10 (10) are legal; 11 stalls the slot, it is never acked.
    assign take = req & own & ((coin == 2'b01) | (coin == 2'b10));
endmodule

module vend_slot_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] coin_0,
    input  logic [1:0] coin_1,
    output logic [1:0] coin_ack,
    output logic [1:0] grant,
    output logic       busy,
    output logic [1:0] vm_in,
    output logic       vm_rst_n,
    input  logic       vm_out,
    input  logic [1:0] vm_change,
    output logic [1:0] vend_done,
    output logic [1:0] change_out,
    output logic       abort
);
    localparam int NUM_SLOTS = 2;

    typedef enum logic [1:0] {IDLE, SESSION, DRAIN} state_t;

    state_t                    state;
    logic                      rr_last;
    logic                      in_session;
    logic                      owner;
    logic                      accept;
    logic                      timeout_hit;
    logic [1:0]                pick;
    logic [NUM_SLOTS-1:0]      take;
    logic [NUM_SLOTS-1:0][1:0] coins;

    if (CNT_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_cnt_w_chk
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    assign coins      = {coin_1, coin_0};
    assign in_session = (state == SESSION);
    assign owner      = grant[1];
    assign accept     = |take;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_lane
        vend_slot_lane u_lane (
            .req  (req[i]),
            .own  (grant[i] & in_session),
            .coin (coins[i]),
            .take (take[i])
        );
    end

    // Tie goes to the slot that did not own the previous session.
    assign pick = (req == 2'b11) ? (rr_last ? 2'b01 : 2'b10) : req;

`ifdef VEND_TIMEOUT_EN
    logic [CNT_W-1:0] idle_cnt;
    logic             abort_q;

    // vm_out in the terminal idle cycle wins over the abort.
    assign timeout_hit = in_session & ~accept & ~vm_out &
                         (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
            abort_q  <= 1'b0;
        end else begin
            abort_q <= timeout_hit;
            if (!in_session || accept)
                idle_cnt <= '0;
            else if (!vm_out)
                idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign abort    = abort_q;
    assign vm_rst_n = reset & ~abort_q;
`else
    assign timeout_hit = 1'b0;
    assign abort       = 1'b0;
    assign vm_rst_n    = reset;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= '0;
            coin_ack   <= '0;
            vm_in      <= '0;
            vend_done  <= '0;
            change_out <= '0;
            busy       <= 1'b0;
            rr_last    <= 1'b1;
        end else begin
            coin_ack   <= '0;
            vm_in      <= '0;
            vend_done  <= '0;
            change_out <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant <= pick;
                        busy  <= 1'b1;
                        state <= SESSION;
                    end
                end
                SESSION: begin
                    if (vm_out) begin
                        vend_done  <= grant;
                        change_out <= vm_change;
                        rr_last    <= owner;
                        grant      <= '0;
                        state      <= DRAIN;
                    end else if (timeout_hit) begin
                        rr_last <= owner;
                        grant   <= '0;
                        state   <= DRAIN;
                    end else if (accept) begin
                        coin_ack <= take;
                        vm_in    <= coins[owner];
                    end
                end
                DRAIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vend_slot_arbiter.sv
// Scoreboard bench for vend_slot_arbiter: each driven cycle pushes its expected outputs,
// popped and compared on the following falling edge.
module tb_vend_slot_arbiter;
`ifdef VEND_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 16;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] req = '0, coin_0 = '0, coin_1 = '0, vm_change = '0;
    logic       vm_out = 1'b0;
    logic [1:0] coin_ack, grant, vm_in, vend_done, change_out;
    logic       busy, vm_rst_n, abort;

    always #5 clock = ~clock;

    vend_slot_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .coin_0     (coin_0),
        .coin_1     (coin_1),
        .coin_ack   (coin_ack),
        .grant      (grant),
        .busy       (busy),
        .vm_in      (vm_in),
        .vm_rst_n   (vm_rst_n),
        .vm_out     (vm_out),
        .vm_change  (vm_change),
        .vend_done  (vend_done),
        .change_out (change_out),
        .abort      (abort)
    );

    typedef struct packed {
        logic [1:0] grant;
        logic       busy;
        logic [1:0] ack;
        logic [1:0] vmin;
        logic [1:0] done;
        logic [1:0] chg;
        logic       abort;
        logic       rstn;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] g, input logic b, input logic [1:0] a,
                                input logic [1:0] v, input logic [1:0] d,
                                input logic [1:0] c, input logic ab);
        exp_t e;
        e.grant = g; e.busy = b; e.ack = a; e.vmin = v;
        e.done = d; e.chg = c; e.abort = ab; e.rstn = ~ab;
        return e;
    endfunction

    task automatic compare();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 2'b01, 2'b00);
            return;
        end
        e = sb.pop_front();
        chk("grant",      grant,             e.grant);
        chk("busy",       {1'b0, busy},      {1'b0, e.busy});
        chk("coin_ack",   coin_ack,          e.ack);
        chk("vm_in",      vm_in,             e.vmin);
        chk("vend_done",  vend_done,         e.done);
        chk("change_out", change_out,        e.chg);
        chk("abort",      {1'b0, abort},     {1'b0, e.abort});
        chk("vm_rst_n",   {1'b0, vm_rst_n},  {1'b0, e.rstn});
    endtask

    // Drive at a falling edge, let one rising edge pass, check at the next falling edge.
    task automatic step(input logic [1:0] r, input logic [1:0] c0, input logic [1:0] c1,
                        input logic vo, input logic [1:0] vc, input exp_t e);
        req = r; coin_0 = c0; coin_1 = c1; vm_out = vo; vm_change = vc;
        sb.push_back(e);
        @(posedge clock);
        @(negedge clock);
        compare();
    endtask

    task automatic pulse_reset();
        exp_t e;
        req = '0; coin_0 = '0; coin_1 = '0; vm_out = 1'b0; vm_change = '0;
        e = mk(2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        e.rstn = 1'b0;
        reset = 1'b0;
        #2;
        sb.push_back(e);
        compare();
        @(negedge clock);
        reset = 1'b1;
    endtask

    exp_t idle_e, rst_e;

    initial begin
        idle_e = mk(2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        rst_e = idle_e;
        rst_e.rstn = 1'b0;

        // reset held for two cycles
        for (int i = 0; i < 2; i++) begin
            sb.push_back(rst_e);
            @(negedge clock);
            compare();
        end
        reset = 1'b1;
        step(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, idle_e);

        // slot 0: coins 5 then 10, vend with change 00
        step(2'b01, 2'b01, 2'b00, 1'b0, 2'b00, mk(2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        step(2'b01, 2'b01, 2'b00, 1'b0, 2'b00, mk(2'b01, 1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0));
        step(2'b01, 2'b10, 2'b00, 1'b0, 2'b00, mk(2'b01, 1'b1, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0));
        step(2'b00, 2'b00, 2'b00, 1'b1, 2'b00, mk(2'b00, 1'b1, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0));
        step(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, idle_e);

        // both request after reset: slot 0 first, non-owner coin ignored, then slot 1
        pulse_reset();
        step(2'b11, 2'b01, 2'b10, 1'b0, 2'b00, mk(2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        step(2'b11, 2'b01, 2'b10, 1'b0, 2'b00, mk(2'b01, 1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0));
        step(2'b10, 2'b00, 2'b10, 1'b1, 2'b01, mk(2'b00, 1'b1, 2'b00, 2'b00, 2'b01, 2'b01, 1'b0));
        step(2'b11, 2'b00, 2'b10, 1'b0, 2'b00, idle_e);
        step(2'b11, 2'b00, 2'b10, 1'b0, 2'b00, mk(2'b10, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));

        // slot 1: illegal coin stalls, then 10 accepted, vend with change 10
        step(2'b10, 2'b00, 2'b11, 1'b0, 2'b00, mk(2'b10, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        step(2'b10, 2'b00, 2'b11, 1'b0, 2'b00, mk(2'b10, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        step(2'b10, 2'b00, 2'b10, 1'b0, 2'b00, mk(2'b10, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0));
        step(2'b00, 2'b00, 2'b00, 1'b1, 2'b10, mk(2'b00, 1'b1, 2'b00, 2'b00, 2'b10, 2'b10, 1'b0));
        step(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, idle_e);

        // vm_out together with a valid coin: vend wins, coin not acked
        step(2'b01, 2'b10, 2'b00, 1'b0, 2'b00, mk(2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        step(2'b01, 2'b10, 2'b00, 1'b1, 2'b01, mk(2'b00, 1'b1, 2'b00, 2'b00, 2'b01, 2'b01, 1'b0));
        step(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, idle_e);

        // vm_out outside a session is ignored
        step(2'b00, 2'b00, 2'b00, 1'b1, 2'b11, idle_e);
        step(2'b00, 2'b00, 2'b00, 1'b1, 2'b11, idle_e);

        // reset mid-session: credit lost, no vend_done, round-robin pointer restored
        step(2'b10, 2'b00, 2'b01, 1'b0, 2'b00, mk(2'b10, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        step(2'b10, 2'b00, 2'b01, 1'b0, 2'b00, mk(2'b10, 1'b1, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0));
        pulse_reset();
        step(2'b00, 2'b00, 2'b00, 1'b1, 2'b11, idle_e);
        step(2'b11, 2'b01, 2'b00, 1'b0, 2'b00, mk(2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        step(2'b01, 2'b01, 2'b00, 1'b0, 2'b00, mk(2'b01, 1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0));

`ifdef VEND_TIMEOUT_EN
        // one coin then idle: abort on the TO-th idle cycle, core reset for that cycle
        for (int i = 0; i < TO - 1; i++)
            step(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, mk(2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        step(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, mk(2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1));
        step(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, idle_e);

        // vm_out in the terminal idle cycle beats the abort
        step(2'b01, 2'b00, 2'b00, 1'b0, 2'b00, mk(2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        for (int i = 0; i < TO - 1; i++)
            step(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, mk(2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        step(2'b00, 2'b00, 2'b00, 1'b1, 2'b00, mk(2'b00, 1'b1, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0));
        step(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, idle_e);
`else
        // no timeout: a stalled session holds until vm_out
        for (int i = 0; i < 20; i++)
            step(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, mk(2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        step(2'b00, 2'b00, 2'b00, 1'b1, 2'b11, mk(2'b00, 1'b1, 2'b00, 2'b00, 2'b01, 2'b11, 1'b0));
        step(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, idle_e);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout sim did not finish");
        $fatal(1);
    end
endmodule
